// File: rtl/inv_sub_bytes_seq.sv
// Iterative AES InvSubBytes stage. A 128-bit state is captured on accept, then
// BYTES_PER_CYCLE bytes per cycle are replaced by their inverse S-box value,
// most significant chunk first. The finished state is held until taken downstream.
module inv_sub_bytes_seq #(
  parameter int unsigned BYTES_PER_CYCLE = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  localparam int unsigned NumChunks = 16 / BYTES_PER_CYCLE;
  localparam int unsigned CntW      = (NumChunks > 1) ? $clog2(NumChunks) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(NumChunks - 1);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [127:0]    work_q, work_d;

  // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    logic [7:0] bb;
    p  = 8'h00;
    aa = a;
    bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) begin
        p = p ^ aa;
      end
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = {1'b0, bb[7:1]};
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 (maps 0 to 0, as the S-box requires).
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] p;
    logic [7:0] r;
    p = x;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  // Inverse affine transform: y_i = x_(i+2) ^ x_(i+5) ^ x_(i+7) ^ 0x05_i.
  function automatic logic [7:0] inv_affine(input logic [7:0] x);
    logic [7:0] r2;
    logic [7:0] r5;
    logic [7:0] r7;
    r2 = {x[1:0], x[7:2]};
    r5 = {x[4:0], x[7:5]};
    r7 = {x[6:0], x[7]};
    return r2 ^ r5 ^ r7 ^ 8'h05;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    return gf_inv(inv_affine(x));
  endfunction

  // Next-state logic: capture, chunked substitution, hold until taken.
  always_comb begin
    logic [3:0] idx;
    logic [6:0] lsb;
    state_d = state_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    idx     = 4'h0;
    lsb     = 7'h00;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          work_d  = in_state;
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        for (int l = 0; l < int'(BYTES_PER_CYCLE); l++) begin
          // Byte k lives at [127-8k -: 8], i.e. its LSB is at 8*(15-k) = {~k, 3'b0}.
          idx = 4'(int'(cnt_q) * int'(BYTES_PER_CYCLE) + l);
          lsb = {~idx, 3'b000};
          work_d[lsb +: 8] = inv_sbox(work_q[lsb +: 8]);
        end
        if (cnt_q == LastCnt) begin
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State, chunk counter and working register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      work_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
    end
  end

  // Outputs decode directly from registered state.
  always_comb begin
    in_ready  = (state_q == StIdle);
    out_valid = (state_q == StDone);
    busy      = (state_q != StIdle);
    out_state = work_q;
  end

endmodule

// File: tb/tb_inv_sub_bytes_seq.sv
// Self-checking bench for inv_sub_bytes_seq: one instance per legal lane count,
// index 2 (four lanes) is the primary device for the sequence checks.
module tb_inv_sub_bytes_seq;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         out_ready;
  logic [127:0] in_state;
  logic [4:0]   ir;
  logic [4:0]   ov;
  logic [4:0]   bz;
  logic [127:0] os [5];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 5; g++) begin : g_dut
    inv_sub_bytes_seq #(.BYTES_PER_CYCLE(1 << g)) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (ir[g]),
      .in_state (in_state),
      .out_valid(ov[g]),
      .out_ready(out_ready),
      .out_state(os[g]),
      .busy     (bz[g])
    );
  end

  typedef struct {
    logic [127:0] din;
    logic [127:0] dout;
  } vec_t;

  localparam logic [127:0] C1In  = 128'h7a9f102789d5f50b2beffd9f3dca4ea7;
  localparam logic [127:0] C1Out = 128'hbd6e7c3df2b5779e0b61216e8b10b689;
  localparam logic [127:0] PatIn = {4{32'h637c1600}};
  localparam logic [127:0] PatOut = {4{32'h0001ff52}};

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0]   inv_tab [256];
  vec_t         vecs [6];
  int           first [5];
  logic [127:0] got_state [5];
  logic [127:0] rnd [3];
  logic [127:0] tmp_b;
  logic [127:0] tmp_in;
  int           lat;
  int           sent;
  int           got;
  int           last_cyc;
  logic         seen;
  logic         acc;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Carry-less product reduced by the AES polynomial, plain integer arithmetic.
  function automatic int gmul(input int a, input int b);
    int p;
    p = 0;
    for (int i = 0; i < 8; i++) begin
      if (((b >> i) & 1) != 0) p = p ^ (a << i);
    end
    for (int k = 14; k >= 8; k--) begin
      if (((p >> k) & 1) != 0) p = p ^ (32'h11b << (k - 8));
    end
    return p;
  endfunction

  function automatic int rotl8(input int v, input int n);
    return ((v << n) | (v >> (8 - n))) & 255;
  endfunction

  // Forward S-box from brute-force inverse plus forward affine, then inverted.
  task automatic build_table();
    int inv;
    int s;
    for (int x = 0; x < 256; x++) begin
      inv = 0;
      if (x != 0) begin
        for (int y = 1; y < 256; y++) begin
          if (gmul(x, y) == 1) inv = y;
        end
      end
      s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 32'h63;
      inv_tab[8'(s)] = 8'(x);
    end
  endtask

  function automatic logic [127:0] ref_isb(input logic [127:0] s);
    logic [127:0] r;
    logic [127:0] t;
    r = '0;
    t = s;
    for (int i = 0; i < 16; i++) begin
      r = {r[119:0], inv_tab[t[127:120]]};
      t = {t[119:0], 8'h00};
    end
    return r;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Steps until the primary instance shows out_valid, bounded at 40 cycles.
  task automatic wait_out(output int cyc);
    cyc = 0;
    while (!ov[2] && cyc < 40) begin
      step();
      cyc++;
    end
  endtask

  task automatic send(input string name, input logic [127:0] d, input logic [127:0] exp);
    int c;
    c = 0;
    while (!ir[2] && c < 20) begin
      step();
      c++;
    end
    in_state = d;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    wait_out(c);
    check({name, " latency"}, 128'(c), 128'd4);
    check({name, " data"}, os[2], exp);
    step();
    check({name, " one-cycle pulse"}, 128'(ov[2]), 128'd0);
  endtask

  initial begin
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    in_state  = '0;
    build_table();

    vecs[0] = '{din: 128'h0, dout: {16{8'h52}}};
    vecs[1] = '{din: C1In, dout: C1Out};
    vecs[2] = '{din: PatIn, dout: PatOut};
    for (int i = 3; i < 6; i++) begin
      vecs[i].din  = rand128();
      vecs[i].dout = ref_isb(vecs[i].din);
    end

    // Asynchronous reset takes effect before any clock edge.
    #3 rst_n = 1'b0;
    #1;
    check("reset out_valid", 128'(ov), 128'd0);
    check("reset busy", 128'(bz), 128'd0);
    check("reset in_ready", 128'(ir), 128'h1f);
    check("reset out_state", os[2], 128'h0);
    step();
    step();
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 6; i++) begin
      send($sformatf("vec%0d", i), vecs[i].din, vecs[i].dout);
    end

    // Backpressure: held in DONE while a new state waits upstream.
    out_ready = 1'b0;
    in_state  = C1In;
    in_valid  = 1'b1;
    step();
    in_valid = 1'b0;
    wait_out(lat);
    check("bp latency", 128'(lat), 128'd4);
    check("bp data", os[2], C1Out);
    tmp_b    = rand128();
    in_state = tmp_b;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check($sformatf("bp hold valid %0d", i), 128'(ov[2]), 128'd1);
      check($sformatf("bp hold data %0d", i), os[2], C1Out);
      check($sformatf("bp hold in_ready %0d", i), 128'(ir[2]), 128'd0);
    end
    out_ready = 1'b1;
    step();
    check("bp leave only: busy", 128'(bz[2]), 128'd0);
    check("bp leave only: in_ready", 128'(ir[2]), 128'd1);
    step();
    in_valid = 1'b0;
    check("bp accept busy", 128'(bz[2]), 128'd1);
    wait_out(lat);
    check("bp new latency", 128'(lat), 128'd4);
    check("bp new data", os[2], ref_isb(tmp_b));
    step();

    // Reset two cycles into RUN aborts the block.
    in_state = C1In;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    #1;
    check("abort busy", 128'(bz[2]), 128'd0);
    check("abort out_state", os[2], 128'h0);
    step();
    rst_n = 1'b1;
    seen  = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      seen = seen | ov[2];
    end
    check("abort no out_valid", 128'(seen), 128'd0);
    check("abort idle", 128'(bz[2]), 128'd0);
    send("after abort", C1In, C1Out);

    // Every lane count: latency N and data, for the pattern and a random state.
    for (int v = 0; v < 2; v++) begin
      tmp_in = (v == 0) ? PatIn : rand128();
      rst_n  = 1'b0;
      step();
      rst_n    = 1'b1;
      step();
      in_state = tmp_in;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
        first[i] = 0;
        got_state[i] = '0;
      end
      for (int cyc = 1; cyc <= 20; cyc++) begin
        step();
        for (int i = 0; i < 5; i++) begin
          if (ov[i] && first[i] == 0) begin
            first[i] = cyc;
            got_state[i] = os[i];
          end
        end
      end
      for (int i = 0; i < 5; i++) begin
        check($sformatf("cfg B=%0d v%0d latency", 1 << i, v), 128'(first[i]), 128'(16 >> i));
        check($sformatf("cfg B=%0d v%0d data", 1 << i, v), got_state[i], ref_isb(tmp_in));
      end
    end

    // Back-to-back with in_valid held: results in order, N+2 apart.
    for (int i = 0; i < 3; i++) rnd[i] = rand128();
    in_state = rnd[0];
    in_valid = 1'b1;
    sent     = 0;
    got      = 0;
    last_cyc = 0;
    for (int cyc = 0; cyc < 60 && got < 3; cyc++) begin
      acc = ir[2] && in_valid;
      step();
      if (acc) begin
        sent++;
        if (sent < 3) in_state = rnd[sent];
        else in_valid = 1'b0;
      end
      if (ov[2]) begin
        check($sformatf("b2b data %0d", got), os[2], ref_isb(rnd[got]));
        if (got > 0) begin
          check($sformatf("b2b spacing %0d", got), 128'(cyc - last_cyc), 128'd6);
        end
        last_cyc = cyc;
        got++;
      end
    end
    in_valid = 1'b0;
    check("b2b result count", 128'(got), 128'd3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/inv_sub_bytes_seq.md
# inv_sub_bytes_seq

Iterative AES InvSubBytes stage that sits directly downstream of `inv_shift_rows` in the decryption round datapath. It consumes the 128-bit state produced by `inv_shift_rows` and applies the inverse S-box to every byte, a configurable number of bytes per cycle. A valid/ready handshake on both sides lets the round controller stall it. It trades latency for S-box area: with the default configuration, 4 inverse S-box instances are shared across 16 bytes.

## Interface
- `BYTES_PER_CYCLE`, default 4. Number of inverse S-box lanes. Legal values are 1, 2, 4, 8 and 16. Define N = 16 / BYTES_PER_CYCLE.
- `clk` input, 1 bit. Single clock; all state changes on its rising edge.
- `rst_n` input, 1 bit. Asynchronous, active-low reset.
- `in_valid` input, 1 bit. Upstream state is valid.
- `in_ready` output, 1 bit. Block can accept a state.
- `in_state` input, 128 bits. State from `inv_shift_rows`. Byte 0 is [127:120] and byte 15 is [7:0] (column-major, FIPS-197 order).
- `out_valid` output, 1 bit. `out_state` holds a finished result.
- `out_ready` input, 1 bit. Downstream accepts the result.
- `out_state` output, 128 bits. InvSubBytes(`in_state`), registered.
- `busy` output, 1 bit. High in RUN or DONE.

## Operation
- Inverse S-box per byte: y = InvSbox(x), exactly as in FIPS-197 Fig. 14. Either a ROM or the GF(2^8) inverse of the inverse affine transform is acceptable; the results must be bit-identical.
- FSM states and transitions:
  - IDLE: `in_ready`=1. On `in_valid`&&`in_ready`, capture `in_state` into the working register, clear the chunk counter, and go to RUN.
  - RUN: each cycle, replace bytes [c·B .. c·B+B-1] of the working register with their InvSbox values (B = BYTES_PER_CYCLE, c = counter). Chunk 0 is the MSB bytes. Increment c. After chunk N-1, go to DONE.
  - DONE: `out_valid`=1 and `out_state` equals the working register, held stable. On `out_ready`=1, go to IDLE.
- `in_ready` = (state == IDLE). `in_valid` is ignored outside IDLE, and `in_state` is sampled only on the accepting edge.
- The counter width is ceil(log2(N)), minimum 1 bit. With N=1, RUN lasts exactly one cycle.
- Each byte is substituted exactly once. No byte is substituted twice and none is left unsubstituted.
- `out_state` may show partial results during RUN. Only the value while `out_valid`=1 is defined.

## Timing
- Reset values (asynchronous, effective immediately on `rst_n`=0):
  - state = IDLE, counter = 0, working register = 0.
  - `out_valid`=0, `out_state`=0, `busy`=0, `in_ready`=1.
- Latency: the state is accepted at edge t0, and `out_valid` rises after edge t0+N. With the default configuration this is 4 cycles.
- Throughput: at most one block per N+2 cycles (accept, N RUN cycles, one DONE cycle with `out_ready`=1). The next accept can happen on the cycle after leaving DONE.
- Backpressure: with `out_ready`=0, the block stays in DONE indefinitely. `out_valid` stays high, `out_state` is unchanged, and `in_ready` stays 0.
- `out_ready` high before DONE has no effect.
- `in_valid` and `out_ready` both high in DONE: leave DONE only; the input is not accepted in that cycle.
- Reset during RUN or DONE: abort. The partial data is discarded, no `out_valid` pulse occurs, and after `rst_n` rises the block behaves as freshly reset.

## Test plan
- Reset, then `in_state`=0, `in_valid` for 1 cycle, `out_ready`=1 → exactly 4 cycles later `out_state`=0x52 repeated in all 16 bytes, with `out_valid` high for 1 cycle.
- FIPS-197 C.1 round 1: `in_state`=7a9f102789d5f50b2beffd9f3dca4ea7 → `out_state`=bd6e7c3df2b5779e0b61216e8b10b689.
- Bytes 63 7c 16 00 repeated 4 times → bytes 00 01 ff 52 repeated. Run for every legal BYTES_PER_CYCLE, checking latency N.
- Hold `out_ready`=0 for 10 cycles after DONE while `in_valid`=1 with a new state → `out_valid` and `out_state` stable, `in_ready`=0, new state not captured. Raise `out_ready`, then the new state is accepted and its result is correct.
- Assert `rst_n`=0 two cycles after accept → `out_valid` never rises. Resend the C.1 vector and the correct result appears.
- Back-to-back: 3 random states with `in_valid` held and `out_ready`=1 → results match a software InvSbox model in order, spaced N+2 cycles apart.
